// File: rtl/program_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes assembled
// 16-bit words into the instruction memory write port, holding the CPU meanwhile.
module program_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              load_instr,
  output logic [ADDR_W-1:0] load_instr_address,
  output logic [WORD_W-1:0] instruction_input,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [7:0]  DepthByte = 8'(DEPTH);

  typedef enum logic [2:0] {
    StIdle, StCount, StHi, StLo, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   n_q;
  logic [CntW-1:0]   wcnt_q;
  logic [CntW-1:0]   wcnt_inc;
  logic [7:0]        hi_q;
  logic [7:0]        csum_q;
  logic              in_busy;

  assign in_busy  = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
  assign wcnt_inc = wcnt_q + 1'b1;
  assign cpu_hold = busy;

  always_comb begin
    byte_ready = 1'b0;
    if (!abort) begin
      byte_ready = (state_q == StCount) || (state_q == StHi) ||
                   (state_q == StLo)    || (state_q == StCsum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      n_q                <= '0;
      wcnt_q             <= '0;
      hi_q               <= '0;
      csum_q             <= '0;
      load_instr         <= 1'b0;
      load_instr_address <= '0;
      instruction_input  <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      err_code           <= 2'b00;
    end else begin
      load_instr <= 1'b0;
      // Abort overrides everything, including a simultaneous start or byte.
      if (in_busy && abort) begin
        state_q  <= StErr;
        busy     <= 1'b0;
        error    <= 1'b1;
        err_code <= 2'b11;
      end else begin
        unique case (state_q)
          StIdle, StDone, StErr: begin
            if (start) begin
              state_q  <= StCount;
              busy     <= 1'b1;
              done     <= 1'b0;
              error    <= 1'b0;
              err_code <= 2'b00;
              csum_q   <= '0;
              wcnt_q   <= '0;
            end
          end
          StCount: begin
            if (byte_valid) begin
              n_q <= byte_data[CntW-1:0];
              if (byte_data == 8'd0 || byte_data > DepthByte) begin
                state_q  <= StErr;
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= 2'b01;
              end else begin
                state_q <= StHi;
              end
            end
          end
          StHi: begin
            if (byte_valid) begin
              hi_q    <= byte_data;
              csum_q  <= csum_q + byte_data;
              state_q <= StLo;
            end
          end
          StLo: begin
            if (byte_valid) begin
              instruction_input  <= {hi_q, byte_data};
              csum_q             <= csum_q + byte_data;
              load_instr         <= 1'b1;
              load_instr_address <= wcnt_q[ADDR_W-1:0];
              state_q            <= StWrite;
            end
          end
          StWrite: begin
            wcnt_q  <= wcnt_inc;
            state_q <= (wcnt_inc == n_q) ? StCsum : StHi;
          end
          StCsum: begin
            if (byte_valid) begin
              busy <= 1'b0;
              if (byte_data == csum_q) begin
                state_q <= StDone;
                done    <= 1'b1;
              end else begin
                state_q  <= StErr;
                error    <= 1'b1;
                err_code <= 2'b10;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framing, backpressure, error paths,
// full-depth image, abort, ignored start and mid-load reset.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        load_instr;
  logic [4:0]  load_instr_address;
  logic [15:0] instruction_input;
  logic        busy, cpu_hold, done, error;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;
  logic [4:0]  wr_addr[$];
  logic [15:0] wr_data[$];

  program_loader #(.ADDR_W(5), .DEPTH(32), .WORD_W(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .byte_valid         (byte_valid),
    .byte_data          (byte_data),
    .byte_ready         (byte_ready),
    .load_instr         (load_instr),
    .load_instr_address (load_instr_address),
    .instruction_input  (instruction_input),
    .busy               (busy),
    .cpu_hold           (cpu_hold),
    .done               (done),
    .error              (error),
    .err_code           (err_code)
  );

  always #5 clk = ~clk;

  // Record every write strobe; byte_ready must be low in the WRITE cycle.
  always @(negedge clk) begin
    if (load_instr === 1'b1) begin
      wr_addr.push_back(load_instr_address);
      wr_data.push_back(instruction_input);
      checks++;
      if (byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write: byte_ready=%b required 0", byte_ready);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    forever begin
      #1;
      if (byte_ready === 1'b1) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 50) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: byte %h not accepted, required accept", b);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    byte_valid = 1'b0;
    @(negedge clk);
    send_byte(b);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({byte_ready, load_instr, load_instr_address, instruction_input, busy, cpu_hold,
         done, error, err_code} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {byte_ready, load_instr, load_instr_address, instruction_input, busy,
                cpu_hold, done, error, err_code});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ready=%b required 0 0", busy, byte_ready);
    end
  endtask

  task automatic test_good_load();
    clear_log();
    do_start();
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL good_count_state: busy=%b hold=%b ready=%b required 1 1 1",
               busy, cpu_hold, byte_ready);
    end
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (load_instr !== 1'b1 || load_instr_address !== 5'd0 || instruction_input !== 16'h0000) begin
      errors++;
      $display("FAIL good_strobe0: strobe=%b addr=%0d data=%h required 1 0 0000",
               load_instr, load_instr_address, instruction_input);
    end
    send_byte(8'h60);
    send_byte(8'h00);
    checks++;
    if (load_instr !== 1'b1 || load_instr_address !== 5'd1 || instruction_input !== 16'h6000) begin
      errors++;
      $display("FAIL good_strobe1: strobe=%b addr=%0d data=%h required 1 1 6000",
               load_instr, load_instr_address, instruction_input);
    end
    send_byte(8'h60);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || err_code !== 2'b00 || busy !== 1'b0 ||
        cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL good_final: done=%b err=%b code=%b busy=%b hold=%b required 1 0 00 0 0",
               done, error, err_code, busy, cpu_hold);
    end
    checks++;
    if (wr_addr.size() != 2) begin
      errors++;
      $display("FAIL good_writes: count=%0d required 2", wr_addr.size());
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    do_start();
    send_gap(8'h02);
    send_gap(8'h00);
    send_gap(8'h00);
    send_gap(8'h60);
    send_gap(8'h00);
    send_gap(8'h60);
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 5'd0 || wr_data[0] !== 16'h0000 ||
        wr_addr[1] !== 5'd1 || wr_data[1] !== 16'h6000) begin
      errors++;
      $display("FAIL bp_writes: count=%0d required 2 writes 0:0000 1:6000", wr_addr.size());
    end
    checks++;
    if (done !== 1'b1 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL bp_done: done=%b code=%b required 1 00", done, err_code);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    do_start();
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h00);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || err_code !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL csum_err: err=%b done=%b code=%b busy=%b required 1 0 10 0",
               error, done, err_code, busy);
    end
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== 16'h1234) begin
      errors++;
      $display("FAIL csum_writes: count=%0d required 1 write 0:1234", wr_addr.size());
    end
  endtask

  task automatic test_bad_count();
    clear_log();
    do_start();
    send_byte(8'h00);
    checks++;
    if (error !== 1'b1 || err_code !== 2'b01) begin
      errors++;
      $display("FAIL count_zero: err=%b code=%b required 1 01", error, err_code);
    end
    do_start();
    checks++;
    if (error !== 1'b0 || err_code !== 2'b00 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL count_restart: err=%b code=%b done=%b busy=%b required 0 00 0 1",
               error, err_code, done, busy);
    end
    send_byte(8'h21);
    checks++;
    if (error !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL count_big: err=%b code=%b busy=%b required 1 01 0", error, err_code, busy);
    end
    checks++;
    if (wr_addr.size() != 0) begin
      errors++;
      $display("FAIL count_writes: count=%0d required 0", wr_addr.size());
    end
  endtask

  task automatic test_full_image();
    logic hold_ok = 1'b1;
    int   bad = 0;
    clear_log();
    do_start();
    send_byte(8'h20);
    for (int i = 0; i < 32; i++) begin
      if (cpu_hold !== 1'b1) hold_ok = 1'b0;
      send_byte(8'h00);
      if (cpu_hold !== 1'b1) hold_ok = 1'b0;
      send_byte(8'(i));
      if (cpu_hold !== 1'b1) hold_ok = 1'b0;
    end
    send_byte(8'hF0);  // sum of 0..31 = 496 -> 0xF0
    checks++;
    if (hold_ok !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: cpu_hold dropped=%b required 1 throughout", ~hold_ok);
    end
    checks++;
    if (wr_addr.size() != 32) begin
      errors++;
      $display("FAIL full_count: count=%0d required 32", wr_addr.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wr_addr[i] !== 5'(i) || wr_data[i] !== 16'(i)) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL full_content: bad_words=%0d required 0", bad);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL full_done: done=%b busy=%b hold=%b required 1 0 0", done, busy, cpu_hold);
    end
  endtask

  task automatic test_abort();
    clear_log();
    do_start();
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h44;
    #1;
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: byte_ready=%b required 0", byte_ready);
    end
    @(negedge clk);
    abort      = 1'b0;
    byte_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || err_code !== 2'b11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_err: err=%b code=%b busy=%b required 1 11 0", error, err_code, busy);
    end
    checks++;
    if (wr_addr.size() != 1 || wr_data[0] !== 16'h1122) begin
      errors++;
      $display("FAIL abort_writes: count=%0d required 1 write 0:1122", wr_addr.size());
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (error !== 1'b1 || err_code !== 2'b11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: err=%b code=%b busy=%b required 1 11 0", error, err_code, busy);
    end
    // Abort during the WRITE cycle: that strobe still lands.
    clear_log();
    do_start();
    send_byte(8'h02);
    send_byte(8'hAB);
    send_byte(8'hCD);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (wr_addr.size() != 1 || wr_data[0] !== 16'hABCD || err_code !== 2'b11) begin
      errors++;
      $display("FAIL abort_write: count=%0d code=%b required 1 write ABCD code 11",
               wr_addr.size(), err_code);
    end
  endtask

  task automatic test_start_ignored();
    clear_log();
    do_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h03);
    checks++;
    if (done !== 1'b1 || wr_addr.size() != 2 || wr_data[1] !== 16'h0002 ||
        wr_addr[1] !== 5'd1) begin
      errors++;
      $display("FAIL start_ignored: done=%b count=%0d required 1 2", done, wr_addr.size());
    end
  endtask

  task automatic test_reset_midload();
    clear_log();
    do_start();
    send_byte(8'h05);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, load_instr, load_instr_address, instruction_input, busy, cpu_hold,
         done, error, err_code} !== 29'd0) begin
      errors++;
      $display("FAIL reset_mid: got %b required all zero",
               {byte_ready, load_instr, load_instr_address, instruction_input, busy,
                cpu_hold, done, error, err_code});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    do_start();
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h78);
    checks++;
    if (done !== 1'b1 || wr_addr.size() != 1 || wr_data[0] !== 16'hABCD ||
        wr_addr[0] !== 5'd0) begin
      errors++;
      $display("FAIL reset_recover: done=%b count=%0d required 1 1", done, wr_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_backpressure();
    test_bad_checksum();
    test_bad_count();
    test_full_image();
    test_abort();
    test_start_ignored();
    test_reset_midload();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
